// File: rtl/div_result_stage.sv
// Registered output stage behind the ALU divider: forms quotient/remainder/flags,
// overrides divide-by-zero results, buffers two entries and counts dbz events.
module div_result_stage #(
    parameter int M  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_quot,
    input  logic [M-1:0]  in_rem,
    input  logic [M-1:0]  in_div,
    input  logic          in_c,
    input  logic          in_n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_quot,
    output logic [M-1:0]  out_rem,
    output logic [3:0]    out_flags,
    output logic [CW-1:0] dbz_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          w_push;
    logic          w_pop;
    logic          w_dbz;
    logic [M-1:0]  w_quot;
    logic [M-1:0]  w_rem;
    logic [3:0]    w_flags;

    logic [M-1:0]  r_head_quot;
    logic [M-1:0]  r_head_rem;
    logic [3:0]    r_head_flags;
    logic [M-1:0]  r_tail_quot;
    logic [M-1:0]  r_tail_rem;
    logic [3:0]    r_tail_flags;
    logic [CW-1:0] r_dbz_count;

    assign in_ready  = ~rst & (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Entry formation; flags are packed {N,Z,C,V}.
    always_comb begin
        w_dbz   = (in_div == '0);
        w_quot  = in_quot;
        w_rem   = in_rem;
        w_flags = {in_n, (in_quot == '0) & ~in_c, in_c, 1'b0};
        if (w_dbz) begin
            w_quot  = '1;
            w_rem   = '0;
            w_flags = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push)           w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop)            w_state_nxt = S_ONE;
            default:                       w_state_nxt = S_EMPTY;
        endcase
    end

    // Head register drives the outputs directly, so it simply keeps the last
    // popped entry when the stage drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_quot  <= '0;
            r_head_rem   <= '0;
            r_head_flags <= '0;
            r_tail_quot  <= '0;
            r_tail_rem   <= '0;
            r_tail_flags <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_quot  <= w_quot;
                        r_head_rem   <= w_rem;
                        r_head_flags <= w_flags;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_quot  <= w_quot;
                        r_head_rem   <= w_rem;
                        r_head_flags <= w_flags;
                    end else if (w_push) begin
                        r_tail_quot  <= w_quot;
                        r_tail_rem   <= w_rem;
                        r_tail_flags <= w_flags;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_head_quot  <= r_tail_quot;
                        r_head_rem   <= r_tail_rem;
                        r_head_flags <= r_tail_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbz_count <= '0;
        end else if (w_push && w_dbz && (r_dbz_count != '1)) begin
            r_dbz_count <= r_dbz_count + CW'(1);
        end
    end

    assign out_quot  = r_head_quot;
    assign out_rem   = r_head_rem;
    assign out_flags = r_head_flags;
    assign dbz_count = r_dbz_count;

endmodule

// File: tb/tb_div_result_stage.sv
// Directed self-checking bench for div_result_stage (M=4, CW=4).
module tb_div_result_stage;

    localparam int M  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  in_quot;
    logic [M-1:0]  in_rem;
    logic [M-1:0]  in_div;
    logic          in_c;
    logic          in_n;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_quot;
    logic [M-1:0]  out_rem;
    logic [3:0]    out_flags;
    logic [CW-1:0] dbz_count;

    int n_cmp = 0;
    int n_bad = 0;

    div_result_stage #(.M(M), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_quot   (in_quot),
        .in_rem    (in_rem),
        .in_div    (in_div),
        .in_c      (in_c),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_flags (out_flags),
        .dbz_count (dbz_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [M-1:0] q, input logic [M-1:0] r,
                         input logic [M-1:0] d, input logic c, input logic n);
        in_valid = v;
        in_quot  = q;
        in_rem   = r;
        in_div   = d;
        in_c     = c;
        in_n     = n;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("rst_out_valid", 16'(out_valid), 16'h0);
        check_eq("rst_dbz", 16'(dbz_count), 16'h0);
        check_eq("rst_in_ready", 16'(in_ready), 16'h0);
        check_eq("rst_out_quot", 16'(out_quot), 16'h0);
        check_eq("rst_flags", 16'(out_flags), 16'h0);

        rst = 1'b0;
        tick();
        check_eq("post_rst_in_ready", 16'(in_ready), 16'h1);

        // single pass: 3 r1, divisor 4
        drive(1'b1, 4'd3, 4'd1, 4'd4, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        check_eq("pass_valid", 16'(out_valid), 16'h1);
        check_eq("pass_quot", 16'(out_quot), 16'h3);
        check_eq("pass_rem", 16'(out_rem), 16'h1);
        check_eq("pass_flags", 16'(out_flags), 16'h0);
        tick();
        check_eq("pass_valid_once", 16'(out_valid), 16'h0);
        check_eq("pass_hold_quot", 16'(out_quot), 16'h3);

        // zero flag
        drive(1'b1, 4'd0, 4'd2, 4'd5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        check_eq("zero_flags", 16'(out_flags), 16'b0100);
        check_eq("zero_rem", 16'(out_rem), 16'h2);
        tick();

        // quot=0 with carry: Z suppressed, N and C pass through
        drive(1'b1, 4'd0, 4'd6, 4'd7, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        check_eq("nc_flags", 16'(out_flags), 16'b1010);
        tick();

        // divide by zero
        drive(1'b1, 4'd5, 4'd3, 4'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        check_eq("dbz_quot", 16'(out_quot), 16'hF);
        check_eq("dbz_rem", 16'(out_rem), 16'h0);
        check_eq("dbz_flags", 16'(out_flags), 16'b0001);
        check_eq("dbz_count1", 16'(dbz_count), 16'h1);
        tick();

        // 15 more dbz pushes streaming through push+pop: saturate at 15
        drive(1'b1, 4'd9, 4'd1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) tick();
        check_eq("dbz_count14", 16'(dbz_count), 16'd14);
        tick();
        check_eq("dbz_count15", 16'(dbz_count), 16'd15);
        tick();
        check_eq("dbz_saturate", 16'(dbz_count), 16'd15);
        check_eq("dbz_stream_valid", 16'(out_valid), 16'h1);
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        tick();
        check_eq("dbz_drained", 16'(out_valid), 16'h0);

        // back-pressure: A, B buffered, C refused
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0);
        tick();
        check_eq("bp_in_ready", 16'(in_ready), 16'h0);
        drive(1'b1, 4'd7, 4'd0, 4'd1, 1'b0, 1'b0);
        tick();
        check_eq("bp_head_a", 16'(out_quot), 16'h1);
        check_eq("bp_valid", 16'(out_valid), 16'h1);
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check_eq("bp_head_b", 16'(out_quot), 16'h2);
        check_eq("bp_b_valid", 16'(out_valid), 16'h1);
        check_eq("bp_in_ready_back", 16'(in_ready), 16'h1);
        tick();
        check_eq("bp_no_c", 16'(out_valid), 16'h0);
        check_eq("bp_hold_b", 16'(out_quot), 16'h2);

        // simultaneous push/pop at count=1
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 4'd0, 4'd5, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 4'd5, 4'd3, 4'd6, 1'b0, 1'b0);
        tick();
        check_eq("pp_head_e", 16'(out_quot), 16'h5);
        check_eq("pp_rem_e", 16'(out_rem), 16'h3);
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        tick();
        check_eq("pp_count1_ready", 16'(in_ready), 16'h1);
        out_ready = 1'b1;
        tick();
        check_eq("pp_count1_drain", 16'(out_valid), 16'h0);

        // reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 4'd6, 4'd1, 4'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd8, 4'd2, 4'd3, 1'b0, 1'b0);
        tick();
        check_eq("full_in_ready", 16'(in_ready), 16'h0);
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        tick();
        check_eq("mid_rst_valid", 16'(out_valid), 16'h0);
        check_eq("mid_rst_dbz", 16'(dbz_count), 16'h0);
        check_eq("mid_rst_quot", 16'(out_quot), 16'h0);
        check_eq("mid_rst_in_ready", 16'(in_ready), 16'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("after_rst_valid", 16'(out_valid), 16'h0);
        check_eq("after_rst_in_ready", 16'(in_ready), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
